serial_tx_p2s: RTL and testbench

Parallel-to-serial converter that feeds the serial sequence detectors, such as the 1101 Mealy detector, one bit per clock. It accepts WIDTH-bit words over a valid/ready handshake into a one-word holding register. It shifts each word out on `output_bit`, which drives the detector's `input_bit`, and marks bit validity and frame boundaries. Back-to-back words stream with no idle gap.

---
 rtl/serial_tx_p2s.sv | 81 ++++++++
 tb/tb_serial_tx_p2s.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_p2s.sv
// serial_tx_p2s: word-to-bitstream shifter with a one-word holding register and frame markers
module serial_tx_p2s #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             output_bit,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] hold, sreg, sreg_n, sh;
  logic [CW-1:0] cnt, cnt_n;
  logic hold_full, accept, take, last, ob_n, bv_n, fs_n, fe_n;
  assign load_ready = ~hold_full;
  assign busy = bit_valid | hold_full;
  assign accept = load_valid & load_ready;
  assign last = (state == SHIFT) && (cnt == LAST);
  assign take = hold_full & ((state == IDLE) | last);
  assign sh = MSB_FIRST ? sreg << 1 : sreg >> 1;
  // Next shifter state: a take reloads from hold, otherwise shift or fall back to idle after the last bit
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    cnt_n = cnt;
    ob_n = output_bit;
    bv_n = bit_valid;
    fs_n = 1'b0;
    fe_n = 1'b0;
    if (take) begin
      state_n = SHIFT;
      sreg_n = hold;
      cnt_n = '0;
      ob_n = MSB_FIRST ? hold[WIDTH-1] : hold[0];
      bv_n = 1'b1;
      fs_n = 1'b1;
    end else if (last) begin
      state_n = IDLE;
      ob_n = IDLE_LEVEL;
      bv_n = 1'b0;
    end else if (state == SHIFT) begin
      sreg_n = sh;
      cnt_n = cnt + CW'(1);
      ob_n = MSB_FIRST ? sh[WIDTH-1] : sh[0];
      fe_n = (cnt_n == LAST);
    end
  end
  // Register holding slot and shifter; accept and take never coincide since ready is low while full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      sreg <= '0;
      cnt <= '0;
      output_bit <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      state <= state_n;
      hold <= accept ? data_in : hold;
      hold_full <= accept | (hold_full & ~take);
      sreg <= sreg_n;
      cnt <= cnt_n;
      output_bit <= ob_n;
      bit_valid <= bv_n;
      frame_start <= fs_n;
      frame_end <= fe_n;
    end
endmodule

// File: tb/tb_serial_tx_p2s.sv
// tb_serial_tx_p2s: directed checks of MSB-first, LSB-first and WIDTH=2 serializers
module tb_serial_tx_p2s;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][7:0] din = '0;
  logic [1:0] din2 = '0;
  logic [2:0] lv = '0;
  logic [2:0] lr, ob, bv, fs, fe, bz;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int d;
    logic [7:0] data;
    logic [7:0] serial;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  serial_tx_p2s #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(din[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .output_bit(ob[0]), .bit_valid(bv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));
  serial_tx_p2s #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(din[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .output_bit(ob[1]), .bit_valid(bv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));
  serial_tx_p2s #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w2 (
    .clk(clk), .rst(rst), .data_in(din2), .load_valid(lv[2]), .load_ready(lr[2]),
    .output_bit(ob[2]), .bit_valid(bv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_din(input int d, input logic [7:0] v);
    if (d == 2) din2 = v[1:0];
    else din[d[0]] = v;
  endtask

  // Streams nw words of w bits with load_valid held; bits holds the emission order, first bit at bits[nb-1]
  task automatic stream(input int d, input int w, input int nw, input logic [3:0][7:0] wd,
                        input logic [31:0] bits, input string tag);
    int idx = 0;
    int nb = w * nw;
    logic hs;
    lv[d] = 1'b1;
    set_din(d, wd[0]);
    for (int n = 0; n <= nb + 1; n++) begin
      hs = lv[d] & lr[d];
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx >= nw) lv[d] = 1'b0;
        else set_din(d, wd[idx]);
      end
      if (n == 0) begin
        chk($sformatf("%s ready_after_hs", tag), lr[d], 0);
        chk($sformatf("%s valid_before_take", tag), bv[d], 0);
        chk($sformatf("%s busy_held", tag), bz[d], 1);
      end else if (n <= nb) begin
        chk($sformatf("%s bit%0d", tag, n), ob[d], bits[nb-n]);
        chk($sformatf("%s valid%0d", tag, n), bv[d], 1);
        chk($sformatf("%s start%0d", tag, n), fs[d], ((n - 1) % w == 0));
        chk($sformatf("%s end%0d", tag, n), fe[d], (n % w == 0));
        chk($sformatf("%s ready%0d", tag, n), lr[d], ((n - 1) % w == 0) || (n >= 1 + (nw - 1) * w));
      end else begin
        chk($sformatf("%s idle_valid", tag), bv[d], 0);
        chk($sformatf("%s idle_level", tag), ob[d], 0);
        chk($sformatf("%s idle_ready", tag), lr[d], 1);
        chk($sformatf("%s idle_busy", tag), bz[d], 0);
        chk($sformatf("%s idle_end", tag), fe[d], 0);
      end
    end
    lv[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] bp_bits;
    logic [7:0] rw;
    vt[0] = '{0, 8'hD0, 8'hD0};
    vt[1] = '{0, 8'h3C, 8'h3C};
    vt[2] = '{0, 8'h81, 8'h81};
    vt[3] = '{0, 8'h01, 8'h01};
    vt[4] = '{1, 8'h0B, 8'hD0};
    vt[5] = '{1, 8'h80, 8'h01};
    vt[6] = '{1, 8'h3C, 8'h3C};
    vt[7] = '{1, 8'hE1, 8'h87};
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ob%0d", d), ob[d], 0);
      chk($sformatf("reset valid%0d", d), bv[d], 0);
      chk($sformatf("reset start%0d", d), fs[d], 0);
      chk($sformatf("reset end%0d", d), fe[d], 0);
      chk($sformatf("reset ready%0d", d), lr[d], 1);
      chk($sformatf("reset busy%0d", d), bz[d], 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      stream(vt[i].d, 8, 1, {24'b0, vt[i].data}, {24'b0, vt[i].serial}, $sformatf("vec%0d", i));
    stream(0, 8, 3, {8'h00, 8'hB4, 8'h00, 8'hFF}, 32'h00FF00B4, "b2b");
    stream(2, 2, 2, {16'h0000, 8'h01, 8'h02}, 32'h00000009, "w2");
    bp_bits = 16'h965A;
    lv[0] = 1'b1;
    din[0] = 8'h96;
    for (int n = 0; n <= 17; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) din[0] = 8'h5A;
      if (n == 2) din[0] = 8'hFF;
      if (n == 9) lv[0] = 1'b0;
      if (n == 0) chk("bp ready_after_hs", lr[0], 0);
      else if (n <= 16) begin
        chk($sformatf("bp bit%0d", n), ob[0], bp_bits[16-n]);
        chk($sformatf("bp ready%0d", n), lr[0], (n == 1) || (n >= 9));
        chk($sformatf("bp start%0d", n), fs[0], (n == 1) || (n == 9));
        chk($sformatf("bp valid%0d", n), bv[0], 1);
      end else begin
        chk("bp idle_valid", bv[0], 0);
        chk("bp idle_ready", lr[0], 1);
      end
    end
    rw = 8'hA5;
    lv[0] = 1'b1;
    din[0] = 8'hA5;
    @(posedge clk);
    #1;
    lv[0] = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rstmid bit%0d", n), ob[0], rw[8-n]);
    end
    #3 rst = 1'b1;
    #1;
    chk("rstmid ob", ob[0], 0);
    chk("rstmid valid", bv[0], 0);
    chk("rstmid ready", lr[0], 1);
    chk("rstmid busy", bz[0], 0);
    chk("rstmid start", fs[0], 0);
    lv[0] = 1'b1;
    din[0] = 8'hFF;
    @(posedge clk);
    #1;
    chk("rst_hs_ignored ready", lr[0], 1);
    chk("rst_hs_ignored busy", bz[0], 0);
    lv[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    stream(0, 8, 1, {24'b0, 8'h3C}, {24'b0, 8'h3C}, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
    $fatal(1, "watchdog");
  end
endmodule
